// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared constants for the BCD seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}, active low.
package bcd_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {BLANK, SCAN} state_t;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low seven-segment decoder; codes 10-15 blank.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  assign o_seg = (i_bcd > 4'd9) ? SEG_BLANK : SEG_LUT[i_bcd];
endmodule

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed NDIG-digit seven-segment scanner with shadowed BCD load.
// Define BCD_LZB_EN to enable leading-zero blanking.
module bcd_scan_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_bcd,
  output logic [6:0]        seg_n,
  output logic [NDIG-1:0]   dig_n,
  output logic              frame_start
);
  localparam int IW = $clog2(NDIG);
  localparam int PW = $clog2(SCAN_DIV);

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_pre, w_pre_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [4*NDIG-1:0] r_active, r_shadow, w_active_nxt;
  logic              r_pending;
  logic [6:0]        r_seg, w_seg;
  logic [NDIG-1:0]   r_dig;
  logic [3:0]        w_digit;
  logic              w_xfer, w_tick, w_wrap, w_on, w_lzb;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= BLANK;
    else        r_state <= w_state_nxt;

  // Outputs are registered from next-state values so seg/dig switch together with idx.
  always_comb begin
    w_xfer       = load_valid & ~r_pending;
    w_tick       = r_state == SCAN && disp_en && r_pre == PW'(SCAN_DIV - 1);
    w_wrap       = w_tick && r_idx == IW'(NDIG - 1);
    w_state_nxt  = (r_state == BLANK && w_xfer) ? SCAN : r_state;
    w_pre_nxt    = w_tick ? '0 : (r_state == SCAN && disp_en) ? r_pre + 1'b1 : r_pre;
    w_idx_nxt    = w_wrap ? '0 : w_tick ? r_idx + 1'b1 : r_idx;
    w_active_nxt = (r_state == BLANK && w_xfer) ? load_bcd :
                   (w_wrap && r_pending) ? r_shadow : r_active;
    w_digit      = w_active_nxt[4*w_idx_nxt +: 4];
    w_on         = w_state_nxt == SCAN && disp_en;
`ifdef BCD_LZB_EN
    w_lzb        = w_idx_nxt != '0 && (w_active_nxt >> (4*w_idx_nxt)) == '0;
`else
    w_lzb        = 1'b0;
`endif
  end

  bcd_to_7seg u_dec (.i_bcd(w_digit), .o_seg(w_seg));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre     <= '0;
      r_idx     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_seg     <= SEG_BLANK;
      r_dig     <= '1;
    end else begin
      r_pre     <= w_pre_nxt;
      r_idx     <= w_idx_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= (r_state == SCAN && w_xfer) ? load_bcd : r_shadow;
      r_pending <= (r_state == SCAN && w_xfer) ? 1'b1 : w_wrap ? 1'b0 : r_pending;
      r_seg     <= (w_on && !w_lzb) ? w_seg : SEG_BLANK;
      r_dig     <= w_on ? ~(NDIG'(1) << w_idx_nxt) : '1;
    end

  assign load_ready  = ~r_pending;
  assign seg_n       = r_seg;
  assign dig_n       = r_dig;
  assign frame_start = w_wrap;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed bench for bcd_scan_ctrl with NDIG=4, SCAN_DIV=4.
module tb_bcd_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_en = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_bcd = '0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_start;

  int n_chk = 0;
  int n_fail = 0;

  bcd_scan_ctrl #(.NDIG(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .load_valid(load_valid),
    .load_ready(load_ready), .load_bcd(load_bcd), .seg_n(seg_n), .dig_n(dig_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] exp_w [3][4];
  logic [3:0] exp_dig;
  int eff, w, ix;
  bit off;

  initial begin
    exp_w[0] = '{7'h12, 7'h00, 7'h10, 7'h79};
    exp_w[1] = '{7'h79, 7'h24, 7'h30, 7'h19};
`ifdef BCD_LZB_EN
    exp_w[2] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    exp_w[2] = '{7'h40, 7'h7F, 7'h40, 7'h40};
`endif
    repeat (3) @(negedge clk);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_dig", dig_n, 4'hF);
    check("rst_rdy", load_ready, 1'b1);
    check("rst_frm", frame_start, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_seg", seg_n, 7'h7F);
      check("idle_dig", dig_n, 4'hF);
      check("idle_rdy", load_ready, 1'b1);
    end
    load_valid = 1'b1;
    load_bcd   = 16'h1985;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 90; k++) begin
      off     = k >= 51 && k <= 60;
      eff     = (k <= 50) ? k : k - 10;
      w       = (eff < 32) ? 0 : (eff < 64) ? 1 : 2;
      ix      = (eff % 16) / 4;
      exp_dig = ~(4'b0001 << ix);
      check("scan_seg", seg_n, off ? 7'h7F : exp_w[w][ix]);
      check("scan_dig", dig_n, off ? 4'hF : exp_dig);
      check("scan_frm", frame_start, !off && (eff % 16) == 15);
      check("scan_rdy", load_ready, !((k >= 19 && k <= 31) || (k >= 71 && k <= 73)));
      if (k == 18) begin load_valid = 1'b1; load_bcd = 16'h4321; end
      if (k == 70) begin load_valid = 1'b1; load_bcd = 16'h00A0; end
      if (k == 19 || k == 71) load_valid = 1'b0;
      if (k == 50) disp_en = 1'b0;
      if (k == 60) disp_en = 1'b1;
      @(negedge clk);
    end
    load_valid = 1'b1;
    load_bcd   = 16'h5555;
    @(negedge clk);
    load_valid = 1'b0;
    check("pend_rdy", load_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", seg_n, 7'h7F);
    check("arst_dig", dig_n, 4'hF);
    check("arst_rdy", load_ready, 1'b1);
    check("arst_frm", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_seg", seg_n, 7'h7F);
      check("post_dig", dig_n, 4'hF);
      check("post_rdy", load_ready, 1'b1);
    end
    load_valid = 1'b1;
    load_bcd   = 16'h0009;
    @(negedge clk);
    load_valid = 1'b0;
    check("new_seg", seg_n, 7'h10);
    check("new_dig", dig_n, 4'hE);
    check("new_rdy", load_ready, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
